// File: rtl/rf_arb_pkg.sv
// Shared types and widths for the register-file write arbiter.
package rf_arb_pkg;

  localparam int RF_IDX_W = 5;
  localparam int XLEN     = 32;

  typedef struct packed {
    logic [RF_IDX_W-1:0] index;
    logic [XLEN-1:0]     value;
  } rf_wr_t;

  localparam rf_wr_t RF_WR_NONE = '{index: 5'd0, value: 32'd0};

  // Index 0 is the hardwired zero register; writes to it are dropped.
  function automatic logic rf_idx_writable(input logic [RF_IDX_W-1:0] idx);
    return (idx != 5'd0);
  endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// In-order FIFO holding long-latency results until the writeback port is free.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   push_i,
  input  rf_wr_t push_data_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output rf_wr_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  rf_wr_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_s;
  logic              pop_s;

  assign full_o  = (count_q == CNT_DEPTH);
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign head_o  = mem_q[rd_ptr_q];

  // Requests are qualified here so a stray push on full or pop on empty is harmless.
  always_comb begin
    push_s   = push_i & ~full_o;
    pop_s    = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !pop_s) begin
      count_d = count_q + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; the occupancy count guards every read.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single-port register-file write arbiter: writeback stage has priority,
// long-latency results queue in a FIFO and request a bubble when starved.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_index_i,
  input  logic [31:0] wb_value_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  lu_index_i,
  input  logic [31:0] lu_value_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_index_o,
  output logic [31:0] rf_value_o,
  output logic        stall_req_o,
  output logic        busy_o
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_ONE   = SC_W'(1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);

  logic            fifo_full_s;
  logic            fifo_empty_s;
  rf_wr_t          fifo_head_s;
  rf_wr_t          lu_entry_s;
  logic            lu_push_s;
  logic            wb_live_s;
  logic            pop_s;

  logic            rf_we_q, rf_we_d;
  rf_wr_t          rf_wr_q, rf_wr_d;
  logic            stall_q, stall_d;
  logic [SC_W-1:0] starve_q, starve_d;

  assign lu_ready_o = ~fifo_full_s;
  assign busy_o     = ~fifo_empty_s;
  assign lu_entry_s = '{index: lu_index_i, value: lu_value_i};

  rf_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (lu_push_s),
    .push_data_i (lu_entry_s),
    .pop_i       (pop_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_o      (fifo_head_s)
  );

  // Arbitration: a live writeback always wins; the FIFO head fills idle slots.
  always_comb begin
    lu_push_s = lu_valid_i & lu_ready_o & rf_idx_writable(lu_index_i);
    wb_live_s = wb_we_i & rf_idx_writable(wb_index_i);
    pop_s     = ~wb_live_s & ~fifo_empty_s;
    rf_we_d   = 1'b0;
    rf_wr_d   = RF_WR_NONE;
    if (wb_live_s) begin
      rf_we_d = 1'b1;
      rf_wr_d = '{index: wb_index_i, value: wb_value_i};
    end else if (pop_s) begin
      rf_we_d = 1'b1;
      rf_wr_d = fifo_head_s;
    end else begin
      rf_we_d = 1'b0;
      rf_wr_d = RF_WR_NONE;
    end
  end

  // Starvation tracking; a pop in the current cycle suppresses the stall so it
  // drops the cycle after the head leaves.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (pop_s || fifo_empty_s) begin
      starve_d = {SC_W{1'b0}};
    end else if (starve_q != SC_LIMIT) begin
      starve_d = starve_q + SC_ONE;
    end else begin
      starve_d = starve_q;
    end
    if ((starve_q == SC_LIMIT) && !pop_s) begin
      stall_d = 1'b1;
    end else begin
      stall_d = 1'b0;
    end
  end

  // Output and starvation registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rf_we_q  <= 1'b0;
      rf_wr_q  <= RF_WR_NONE;
      stall_q  <= 1'b0;
      starve_q <= {SC_W{1'b0}};
    end else begin
      rf_we_q  <= rf_we_d;
      rf_wr_q  <= rf_wr_d;
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign rf_we_o     = rf_we_q;
  assign rf_index_o  = rf_wr_q.index;
  assign rf_value_o  = rf_wr_q.value;
  assign stall_req_o = stall_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with hand-computed expectations.
module tb_rf_write_arbiter;

  logic        clk_i;
  logic        reset_i;
  logic        wb_we_i;
  logic [4:0]  wb_index_i;
  logic [31:0] wb_value_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_index_i;
  logic [31:0] lu_value_i;
  logic        rf_we_o;
  logic [4:0]  rf_index_o;
  logic [31:0] rf_value_o;
  logic        stall_req_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  rf_write_arbiter dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .wb_we_i     (wb_we_i),
    .wb_index_i  (wb_index_i),
    .wb_value_i  (wb_value_i),
    .lu_valid_i  (lu_valid_i),
    .lu_ready_o  (lu_ready_o),
    .lu_index_i  (lu_index_i),
    .lu_value_i  (lu_value_i),
    .rf_we_o     (rf_we_o),
    .rf_index_o  (rf_index_o),
    .rf_value_o  (rf_value_o),
    .stall_req_o (stall_req_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk = n_chk + 1;
    if (obs === exp_v) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] idx,
                        input logic [31:0] val);
    chk({tag, "_we"},  {31'd0, rf_we_o}, {31'd0, we});
    chk({tag, "_idx"}, {27'd0, rf_index_o}, {27'd0, idx});
    chk({tag, "_val"}, rf_value_o, val);
  endtask

  task automatic idle_inputs();
    wb_we_i    = 1'b0;
    wb_index_i = 5'd0;
    wb_value_i = 32'd0;
    lu_valid_i = 1'b0;
    lu_index_i = 5'd0;
    lu_value_i = 32'd0;
  endtask

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    tick();
    tick();
    chk_rf("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
    chk("rst_ready", {31'd0, lu_ready_o}, 32'd1);
    reset_i = 1'b0;
    tick();

    // Plain writeback, one-cycle latency then idle zeros.
    wb_we_i = 1'b1; wb_index_i = 5'd5; wb_value_i = 32'hDEADBEEF;
    tick();
    idle_inputs();
    chk_rf("wb", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk_rf("wb_idle", 1'b0, 5'd0, 32'd0);

    // Single LU result: written two cycles after acceptance.
    lu_valid_i = 1'b1; lu_index_i = 5'd3; lu_value_i = 32'h11;
    chk("lu1_ready", {31'd0, lu_ready_o}, 32'd1);
    tick();
    idle_inputs();
    chk("lu1_busy_c1", {31'd0, busy_o}, 32'd1);
    chk("lu1_we_c1", {31'd0, rf_we_o}, 32'd0);
    tick();
    chk_rf("lu1_c2", 1'b1, 5'd3, 32'h11);
    chk("lu1_busy_c2", {31'd0, busy_o}, 32'd0);
    tick();
    chk("lu1_we_c3", {31'd0, rf_we_o}, 32'd0);

    // Starvation: two LU entries behind a continuously live writeback.
    wb_we_i = 1'b1; wb_index_i = 5'd7; wb_value_i = 32'h70;
    lu_valid_i = 1'b1; lu_index_i = 5'd1; lu_value_i = 32'hA1;
    tick();
    lu_index_i = 5'd2; lu_value_i = 32'hA2; wb_value_i = 32'h71;
    chk_rf("stv_wb0", 1'b1, 5'd7, 32'h70);
    tick();
    lu_valid_i = 1'b0; wb_value_i = 32'h72;
    chk("stv_full_ready", {31'd0, lu_ready_o}, 32'd0);
    chk_rf("stv_wb1", 1'b1, 5'd7, 32'h71);
    tick();
    tick();
    tick();
    chk("stv_stall_early", {31'd0, stall_req_o}, 32'd0);
    tick();
    chk("stv_stall_on", {31'd0, stall_req_o}, 32'd1);
    chk_rf("stv_wb_still", 1'b1, 5'd7, 32'h72);
    wb_we_i = 1'b0;
    tick();
    chk_rf("stv_pop1", 1'b1, 5'd1, 32'hA1);
    chk("stv_stall_off", {31'd0, stall_req_o}, 32'd0);
    chk("stv_ready_again", {31'd0, lu_ready_o}, 32'd1);
    tick();
    chk_rf("stv_pop2", 1'b1, 5'd2, 32'hA2);
    chk("stv_busy_end", {31'd0, busy_o}, 32'd0);
    idle_inputs();
    tick();

    // Index 0 on both sources is dropped.
    lu_valid_i = 1'b1; lu_index_i = 5'd0; lu_value_i = 32'hFF;
    wb_we_i = 1'b1; wb_index_i = 5'd0; wb_value_i = 32'h55;
    tick();
    idle_inputs();
    chk("z_we0", {31'd0, rf_we_o}, 32'd0);
    chk("z_busy0", {31'd0, busy_o}, 32'd0);
    tick();
    chk("z_we1", {31'd0, rf_we_o}, 32'd0);
    chk("z_busy1", {31'd0, busy_o}, 32'd0);

    // Fill the FIFO, then reset asynchronously between clock edges.
    wb_we_i = 1'b1; wb_index_i = 5'd9; wb_value_i = 32'h90;
    lu_valid_i = 1'b1; lu_index_i = 5'd4; lu_value_i = 32'hB4;
    tick();
    lu_index_i = 5'd5; lu_value_i = 32'hB5;
    tick();
    lu_valid_i = 1'b0;
    chk("ar_full", {31'd0, lu_ready_o}, 32'd0);
    chk("ar_we_pre", {31'd0, rf_we_o}, 32'd1);
    #3;
    reset_i = 1'b1;
    #1;
    chk_rf("ar_async", 1'b0, 5'd0, 32'd0);
    chk("ar_busy", {31'd0, busy_o}, 32'd0);
    chk("ar_ready", {31'd0, lu_ready_o}, 32'd1);
    chk("ar_stall", {31'd0, stall_req_o}, 32'd0);
    idle_inputs();
    tick();
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_post_we", {31'd0, rf_we_o}, 32'd0);
      chk("ar_post_busy", {31'd0, busy_o}, 32'd0);
    end

    // Simultaneous push and pop with one entry resident, across pointer wrap.
    lu_valid_i = 1'b1; lu_index_i = 5'd10; lu_value_i = 32'h100;
    tick();
    for (int i = 0; i < 8; i++) begin
      lu_index_i = 5'(11 + i);
      lu_value_i = 32'h101 + 32'(i);
      chk("pp_ready", {31'd0, lu_ready_o}, 32'd1);
      tick();
      chk_rf("pp", 1'b1, 5'(10 + i), 32'h100 + 32'(i));
      chk("pp_busy", {31'd0, busy_o}, 32'd1);
    end
    lu_valid_i = 1'b0;
    tick();
    chk_rf("pp_last", 1'b1, 5'd18, 32'h108);
    chk("pp_busy_end", {31'd0, busy_o}, 32'd0);
    tick();
    chk("pp_idle", {31'd0, rf_we_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
